// File: rtl/fb_fade_pipeline.sv
// fb_fade_pipeline: fade engine between the frame-buffer pixel stream and
// the frame-buffer writer. Qualifying pixels (visible, valid, age != 0)
// pass through a 2-stage age/colour pipeline and are queued as write-back
// requests in a first-word-fall-through FIFO with overflow accounting.
module fb_fade_pipeline #(
    parameter int PIXEL_BITS      = 12,
    parameter int AGE_BITS        = 4,
    parameter int ADDR_WIDTH      = 20,
    parameter int FIFO_ADDR_SIZE  = 3,
    parameter int ALMOST_FULL_BUF = 2,
    parameter int DROP_BITS       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_visible,
    input  logic [ADDR_WIDTH-1:0]          in_addr,
    input  logic [AGE_BITS+PIXEL_BITS-1:0] in_data,
    input  logic [1:0]                     fade_mode,
    input  logic [AGE_BITS-1:0]            step_age,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic [AGE_BITS+PIXEL_BITS-1:0] out_data,
    output logic                           almost_full,
    output logic [DROP_BITS-1:0]           drop_count,
    input  logic                           drop_clear
);

    localparam int COLOR_BITS = PIXEL_BITS / 3;
    localparam int DATA_BITS  = AGE_BITS + PIXEL_BITS;
    localparam int DEPTH      = 1 << FIFO_ADDR_SIZE;
    localparam int CNT_BITS   = FIFO_ADDR_SIZE + 1;

    localparam logic [CNT_BITS-1:0]       DEPTH_C  = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0]       AF_LIMIT = CNT_BITS'(ALMOST_FULL_BUF);
    localparam logic [CNT_BITS-1:0]       CNT_ONE  = CNT_BITS'(1);
    localparam logic [FIFO_ADDR_SIZE-1:0] PTR_ONE  = FIFO_ADDR_SIZE'(1);
    localparam logic [AGE_BITS-1:0]       AGE_ONE  = AGE_BITS'(1);
    localparam logic [DROP_BITS-1:0]      DROP_ONE = DROP_BITS'(1);
    localparam logic [DROP_BITS-1:0]      DROP_MAX = {DROP_BITS{1'b1}};

    // Halve every colour channel independently (logical shift, zero fill)
    function automatic logic [PIXEL_BITS-1:0] halve_color(input logic [PIXEL_BITS-1:0] c);
        logic [PIXEL_BITS-1:0] r;
        r = {PIXEL_BITS{1'b0}};
        for (int k = 0; k < 3; k++) begin
            r[k*COLOR_BITS +: COLOR_BITS] = {1'b0, c[k*COLOR_BITS+1 +: COLOR_BITS-1]};
        end
        return r;
    endfunction

    // Input qualification
    logic                  req_s;
    logic [AGE_BITS-1:0]   in_age_s;

    // Stage 1
    logic                  s1_valid_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q;
    logic [AGE_BITS-1:0]   s1_age_q;
    logic [PIXEL_BITS-1:0] s1_color_q;
    logic [1:0]            s1_mode_q;
    logic [AGE_BITS-1:0]   s1_step_q;

    // Stage 2
    logic [AGE_BITS-1:0]   s2_age_s;
    logic [PIXEL_BITS-1:0] halved_s;
    logic [PIXEL_BITS-1:0] fade_color_s;
    logic [PIXEL_BITS-1:0] s2_color_s;
    logic                  s2_valid_q;
    logic [ADDR_WIDTH-1:0] s2_addr_q;
    logic [DATA_BITS-1:0]  s2_data_q;

    // FIFO
    logic [ADDR_WIDTH-1:0]     addr_mem_q [DEPTH];
    logic [DATA_BITS-1:0]      data_mem_q [DEPTH];
    logic [FIFO_ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]       count_q, count_d;
    logic [CNT_BITS-1:0]       free_d;
    logic                      out_valid_q, out_valid_d;
    logic                      af_q, af_d;
    logic                      full_s, pop_s, wr_s, drop_s;
    logic [DROP_BITS-1:0]      drop_q, drop_d;

    assign in_age_s = in_data[DATA_BITS-1 -: AGE_BITS];
    assign req_s    = in_valid && in_visible && (in_age_s != {AGE_BITS{1'b0}});

    // Stage-1 valid bit, flushed by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= req_s;
        end
    end

    // Stage-1 payload capture; contents are ignored while the valid bit is low
    always_ff @(posedge clk) begin
        if (req_s) begin
            s1_addr_q  <= in_addr;
            s1_age_q   <= in_age_s;
            s1_color_q <= in_data[PIXEL_BITS-1:0];
            s1_mode_q  <= fade_mode;
            s1_step_q  <= step_age;
        end
    end

    // Next age and faded colour; age is at least 1 here so no underflow
    always_comb begin
        s2_age_s     = s1_age_q - AGE_ONE;
        halved_s     = halve_color(s1_color_q);
        fade_color_s = s1_color_q;
        case (s1_mode_q)
            2'd1: begin
                if (s2_age_s == s1_step_q) begin
                    fade_color_s = halved_s;
                end else begin
                    fade_color_s = s1_color_q;
                end
            end
            2'd2:    fade_color_s = halved_s;
            default: fade_color_s = s1_color_q;
        endcase
        if (s2_age_s == {AGE_BITS{1'b0}}) begin
            s2_color_s = {PIXEL_BITS{1'b0}};
        end else begin
            s2_color_s = fade_color_s;
        end
    end

    // Stage-2 valid bit, flushed by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
        end
    end

    // Stage-2 write-request payload
    always_ff @(posedge clk) begin
        if (s1_valid_q) begin
            s2_addr_q <= s1_addr_q;
            s2_data_q <= {s2_age_s, s2_color_s};
        end
    end

    // FIFO control: a full FIFO still accepts a write when the head pops in the same cycle
    always_comb begin
        pop_s  = out_valid_q && out_ready;
        full_s = (count_q == DEPTH_C);
        wr_s   = s2_valid_q && (!full_s || pop_s);
        drop_s = s2_valid_q && full_s && !pop_s;

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        free_d      = DEPTH_C - count_d;
        af_d        = (free_d <= AF_LIMIT);
        out_valid_d = (count_d != {CNT_BITS{1'b0}});

        if (drop_clear) begin
            drop_d = {DROP_BITS{1'b0}};
        end else if (drop_s && (drop_q != DROP_MAX)) begin
            drop_d = drop_q + DROP_ONE;
        end else begin
            drop_d = drop_q;
        end
    end

    // FIFO pointers, occupancy, status flags and drop counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {FIFO_ADDR_SIZE{1'b0}};
            rd_ptr_q    <= {FIFO_ADDR_SIZE{1'b0}};
            count_q     <= {CNT_BITS{1'b0}};
            out_valid_q <= 1'b0;
            af_q        <= 1'b0;
            drop_q      <= {DROP_BITS{1'b0}};
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            af_q        <= af_d;
            drop_q      <= drop_d;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (wr_s) begin
            addr_mem_q[wr_ptr_q] <= s2_addr_q;
            data_mem_q[wr_ptr_q] <= s2_data_q;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_addr    = addr_mem_q[rd_ptr_q];
    assign out_data    = data_mem_q[rd_ptr_q];
    assign almost_full = af_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_fb_fade_pipeline.sv
// Directed testbench for fb_fade_pipeline. A second instance with a 3-bit
// drop counter shares all inputs so that counter saturation is reachable.
module tb_fb_fade_pipeline;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_visible;
    logic [19:0] in_addr;
    logic [15:0] in_data;
    logic [1:0]  fade_mode;
    logic [3:0]  step_age;
    logic        out_ready;
    logic        drop_clear;

    logic        out_valid;
    logic [19:0] out_addr;
    logic [15:0] out_data;
    logic        almost_full;
    logic [15:0] drop_count;

    logic        sat_out_valid;
    logic [19:0] sat_out_addr;
    logic [15:0] sat_out_data;
    logic        sat_almost_full;
    logic [2:0]  sat_drop_count;

    int err_cnt = 0;
    int chk_cnt = 0;

    fb_fade_pipeline dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_visible(in_visible),
        .in_addr(in_addr), .in_data(in_data), .fade_mode(fade_mode), .step_age(step_age),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
        .almost_full(almost_full), .drop_count(drop_count), .drop_clear(drop_clear)
    );

    fb_fade_pipeline #(.DROP_BITS(3)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_visible(in_visible),
        .in_addr(in_addr), .in_data(in_data), .fade_mode(fade_mode), .step_age(step_age),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_addr(sat_out_addr),
        .out_data(sat_out_data), .almost_full(sat_almost_full), .drop_count(sat_drop_count),
        .drop_clear(drop_clear)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [19:0] a, input logic [15:0] d);
        in_valid   = v;
        in_visible = 1'b1;
        in_addr    = a;
        in_data    = d;
    endtask

    // One-cycle request with the given fade settings
    task automatic send(input logic [19:0] a, input logic [15:0] d,
                        input logic [1:0] m, input logic [3:0] s);
        fade_mode = m;
        step_age  = s;
        drive(1'b1, a, d);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for the head entry, compare it, then pop it
    task automatic expect_out(input string tag, input logic [19:0] a, input logic [15:0] d);
        for (int n = 0; n < 10 && !out_valid; n++) tick();
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (out_valid) begin
            check_eq({tag, "_addr"}, 64'(out_addr), 64'(a));
            check_eq({tag, "_data"}, 64'(out_data), 64'(d));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [11:0] col;
        reset      = 1'b1;
        in_valid   = 1'b1;
        in_visible = 1'b1;
        in_addr    = 20'h00123;
        in_data    = {4'd4, 12'hF84};
        fade_mode  = 2'd0;
        step_age   = 4'd0;
        out_ready  = 1'b0;
        drop_clear = 1'b0;

        // Reset held 3 cycles with a qualifying input present
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_out_valid", 64'(out_valid), 64'd0);
            check_eq("rst_drop", 64'(drop_count), 64'd0);
        end
        reset = 1'b0;
        drive(1'b1, 20'h00123, {4'd3, 12'hF84});
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("lat_edge2", 64'(out_valid), 64'd0);
        tick();
        check_eq("lat_edge3", 64'(out_valid), 64'd1);
        check_eq("lat_af", 64'(almost_full), 64'd0);
        expect_out("m0", 20'h00123, {4'd2, 12'hF84});
        check_eq("m0_empty", 64'(out_valid), 64'd0);

        // Mode 0 corner cases
        send(20'h00200, {4'd1, 12'hF84}, 2'd0, 4'd0);
        expect_out("age1", 20'h00200, {4'd0, 12'h000});
        send(20'h00201, {4'd0, 12'hF84}, 2'd0, 4'd0);
        idle(5);
        check_eq("age0_none", 64'(out_valid), 64'd0);
        fade_mode  = 2'd0;
        in_valid   = 1'b1;
        in_visible = 1'b0;
        in_addr    = 20'h00202;
        in_data    = {4'd3, 12'hF84};
        tick();
        in_valid   = 1'b0;
        in_visible = 1'b1;
        idle(5);
        check_eq("invis_none", 64'(out_valid), 64'd0);

        // Fade curves
        send(20'h00300, {4'd3, 12'hF84}, 2'd1, 4'd2);
        expect_out("m1_hit", 20'h00300, {4'd2, 12'h742});
        send(20'h00301, {4'd4, 12'hF84}, 2'd1, 4'd2);
        expect_out("m1_miss", 20'h00301, {4'd3, 12'hF84});
        send(20'h00302, {4'd4, 12'hF84}, 2'd2, 4'd0);
        expect_out("m2", 20'h00302, {4'd3, 12'h742});
        send(20'h00303, {4'd3, 12'hF84}, 2'd3, 4'd2);
        expect_out("m3", 20'h00303, {4'd2, 12'hF84});
        fade_mode = 2'd0;

        // Backpressure and ordering: 8 back-to-back, almost_full at 6 entries
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                col = 12'h111 * 12'(c);
                drive(1'b1, 20'(c), {4'd5, col});
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c == 6) check_eq("af_at5", 64'(almost_full), 64'd0);
            if (c == 7) check_eq("af_at6", 64'(almost_full), 64'd1);
        end
        check_eq("bp_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 8; i++) begin
            col = 12'h111 * 12'(i);
            expect_out("order", 20'(i), {4'd4, col});
        end
        check_eq("bp_empty", 64'(out_valid), 64'd0);
        check_eq("bp_af_clear", 64'(almost_full), 64'd0);

        // Overflow: 12 requests into 8 entries
        for (int c = 0; c < 12; c++) begin
            drive(1'b1, 20'(16 + c), {4'd6, 12'(16 + c)});
            tick();
        end
        in_valid = 1'b0;
        idle(3);
        check_eq("ovf_drop", 64'(drop_count), 64'd4);
        check_eq("ovf_drop_sat", 64'(sat_drop_count), 64'd4);
        check_eq("ovf_af", 64'(almost_full), 64'd1);
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 20'(28 + c), {4'd6, 12'(28 + c)});
            tick();
        end
        in_valid = 1'b0;
        idle(3);
        check_eq("ovf_drop10", 64'(drop_count), 64'd10);
        check_eq("sat_max", 64'(sat_drop_count), 64'd7);

        // Full FIFO, pop and write on the same edge: no drop
        drive(1'b1, 20'd40, {4'd6, 12'd40});
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("popwr_drop", 64'(drop_count), 64'd10);
        check_eq("popwr_full", 64'(almost_full), 64'd1);

        // Clear coinciding with a drop
        drive(1'b1, 20'd42, {4'd6, 12'd42});
        tick();
        in_valid = 1'b0;
        tick();
        drop_clear = 1'b1;
        tick();
        drop_clear = 1'b0;
        check_eq("clr_drop", 64'(drop_count), 64'd0);
        check_eq("clr_drop_sat", 64'(sat_drop_count), 64'd0);
        send(20'd41, {4'd6, 12'd41}, 2'd0, 4'd0);
        idle(3);
        check_eq("drop_after_clr", 64'(drop_count), 64'd1);

        // Head order after overflow: 17,18,19 (16 popped, 40 appended)
        for (int i = 17; i < 20; i++) expect_out("ovf_order", 20'(i), {4'd5, 12'(i)});

        // Reset with 5 entries queued and one request in flight
        send(20'd50, {4'd6, 12'd50}, 2'd0, 4'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mrst_valid", 64'(out_valid), 64'd0);
        check_eq("mrst_af", 64'(almost_full), 64'd0);
        check_eq("mrst_drop", 64'(drop_count), 64'd0);
        idle(5);
        check_eq("mrst_flushed", 64'(out_valid), 64'd0);
        drive(1'b1, 20'h00077, {4'd2, 12'h0AB});
        tick();
        in_valid = 1'b0;
        tick();
        check_eq("mrst_lat2", 64'(out_valid), 64'd0);
        tick();
        check_eq("mrst_lat3", 64'(out_valid), 64'd1);
        expect_out("mrst_data", 20'h00077, {4'd1, 12'h0AB});

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
